// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: picks the oldest ready entry by ROB
// age and drives a registered front/front_pos issue request.
module rs_issue_sched #(
    parameter int RS_SIZ = 16,
    parameter int RS_W   = 4,
    parameter int ROB_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ready,
    input  logic                    clear,
    input  logic [RS_SIZ-1:0]       ent_valid,
    input  logic [RS_SIZ-1:0]       ent_rdy,
    input  logic [RS_SIZ*ROB_W-1:0] ent_robpos,
    input  logic [ROB_W-1:0]        rob_head,
    input  logic                    alu_busy,
    output logic                    front,
    output logic [RS_W-1:0]         front_pos,
    output logic [1:0]              sched_state,
    output logic [31:0]             issue_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                front_d;
    logic [RS_W-1:0]     pos_d;
    logic [31:0]         cnt_d;

    logic [RS_SIZ-1:0]   last_mask;
    logic [RS_SIZ-1:0]   cand;
    logic [ROB_W-1:0]    age [RS_SIZ];
    logic [RS_W-1:0]     win_idx;
    logic                any_cand;

    // The station still shows the just-issued entry busy for one cycle.
    always_comb begin
        last_mask = '0;
        if (front) begin
            last_mask[front_pos] = 1'b1;
        end
    end

    assign cand     = ent_valid & ent_rdy & ~last_mask;
    assign any_cand = |cand;

    // Age relative to the head wraps naturally in ROB_W-bit arithmetic.
    always_comb begin
        for (int i = 0; i < RS_SIZ; i++) begin
            age[i] = ent_robpos[i*ROB_W +: ROB_W] - rob_head;
        end
    end

    // Strict less-than keeps the lowest index on (illegal) equal ages.
    always_comb begin
        logic             found;
        logic [ROB_W-1:0] best_age;
        found    = 1'b0;
        best_age = '1;
        win_idx  = '0;
        for (int i = 0; i < RS_SIZ; i++) begin
            if (cand[i] && (!found || age[i] < best_age)) begin
                found    = 1'b1;
                best_age = age[i];
                win_idx  = RS_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        front_d = front;
        pos_d   = front_pos;
        cnt_d   = issue_cnt;
        unique case (1'b1)
            !any_cand: begin
                state_d = IDLE;
                front_d = 1'b0;
            end
            any_cand && alu_busy: begin
                state_d = HOLD;
                front_d = 1'b0;
            end
            any_cand && !alu_busy: begin
                state_d = ISSUE;
                front_d = 1'b1;
                pos_d   = win_idx;
                cnt_d   = issue_cnt + 32'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            front     <= 1'b0;
            front_pos <= '0;
            issue_cnt <= '0;
        end else if (ready) begin
            if (clear) begin
                state_q   <= IDLE;
                front     <= 1'b0;
                front_pos <= '0;
                issue_cnt <= '0;
            end else begin
                state_q   <= state_d;
                front     <= front_d;
                front_pos <= pos_d;
                issue_cnt <= cnt_d;
            end
        end
    end

    assign sched_state = state_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed scenarios plus randomized traffic
// checked against an age-ordering reference model.
module tb_rs_issue_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        clear;
    logic [15:0] ent_valid;
    logic [15:0] ent_rdy;
    logic [63:0] ent_robpos;
    logic [3:0]  rob_head;
    logic        alu_busy;
    logic        front;
    logic [3:0]  front_pos;
    logic [1:0]  sched_state;
    logic [31:0] issue_cnt;

    logic [3:0]  tag [16];

    bit          m_front = 1'b0;
    logic [3:0]  m_pos   = '0;
    logic [1:0]  m_state = '0;
    logic [31:0] m_cnt   = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rs_issue_sched dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .clear      (clear),
        .ent_valid  (ent_valid),
        .ent_rdy    (ent_rdy),
        .ent_robpos (ent_robpos),
        .rob_head   (rob_head),
        .alu_busy   (alu_busy),
        .front      (front),
        .front_pos  (front_pos),
        .sched_state(sched_state),
        .issue_cnt  (issue_cnt)
    );

    // Reference: oldest (smallest wrapped distance from head) wins,
    // the entry issued last cycle is excluded.
    task automatic tick();
        int w;
        int wa;
        int a;
        for (int i = 0; i < 16; i++) ent_robpos[i*4 +: 4] = tag[i];
        if (reset || (ready && clear)) begin
            m_front = 1'b0;
            m_pos   = '0;
            m_state = 2'd0;
            m_cnt   = '0;
        end else if (ready) begin
            w  = -1;
            wa = 0;
            for (int i = 0; i < 16; i++) begin
                if (ent_valid[i] && ent_rdy[i] && !(m_front && m_pos == i)) begin
                    a = (int'(tag[i]) - int'(rob_head) + 16) % 16;
                    if (w < 0 || a < wa) begin
                        w  = i;
                        wa = a;
                    end
                end
            end
            if (w < 0) begin
                m_state = 2'd0;
                m_front = 1'b0;
            end else if (alu_busy) begin
                m_state = 2'd2;
                m_front = 1'b0;
            end else begin
                m_state = 2'd1;
                m_front = 1'b1;
                m_pos   = 4'(w);
                m_cnt   = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic prep();
        ready     = 1'b1;
        reset     = 1'b0;
        alu_busy  = 1'b0;
        ent_valid = '0;
        ent_rdy   = '0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ready     = 1'b1;
        clear     = 1'b0;
        alu_busy  = 1'b0;
        ent_valid = '1;
        ent_rdy   = '1;
        rob_head  = 4'($urandom);
        for (int i = 0; i < 16; i++) tag[i] = 4'($urandom);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (front !== 1'b0 || issue_cnt !== 32'd0 || sched_state !== 2'd0) begin
                errors++;
                $display("FAIL reset c=%0d got front=%0b cnt=%0d st=%0d exp 0/0/0",
                         c, front, issue_cnt, sched_state);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (front !== 1'b1 || front_pos !== m_pos || issue_cnt !== 32'd1) begin
            errors++;
            $display("FAIL reset_first_issue got front=%0b pos=%0d cnt=%0d exp 1/%0d/1",
                     front, front_pos, issue_cnt, m_pos);
        end
    endtask

    task automatic test_age_wrap();
        int exp_pos [3];
        exp_pos = '{5, 9, 3};
        prep();
        rob_head = 4'd14;
        tag[3]   = 4'd1;
        tag[5]   = 4'd15;
        tag[9]   = 4'd0;
        ent_valid = 16'h0228;
        ent_rdy   = 16'h0228;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (front !== 1'b1 || front_pos !== 4'(exp_pos[k])) begin
                errors++;
                $display("FAIL age_wrap k=%0d got front=%0b pos=%0d exp 1/%0d",
                         k, front, front_pos, exp_pos[k]);
            end
            ent_valid[exp_pos[k]] = 1'b0;
        end
        checks++;
        if (issue_cnt !== 32'd3) begin
            errors++;
            $display("FAIL age_wrap_cnt got %0d exp 3", issue_cnt);
        end
        tick();
        checks++;
        if (front !== 1'b0 || sched_state !== 2'd0) begin
            errors++;
            $display("FAIL age_wrap_idle got front=%0b st=%0d exp 0/0", front, sched_state);
        end
    endtask

    task automatic test_busy_hold();
        prep();
        ent_valid = 16'h0004;
        ent_rdy   = 16'h0004;
        alu_busy  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sched_state !== 2'd2 || front !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold c=%0d got st=%0d front=%0b exp 2/0",
                         c, sched_state, front);
            end
        end
        alu_busy = 1'b0;
        tick();
        checks++;
        if (front !== 1'b1 || front_pos !== 4'd2 || sched_state !== 2'd1) begin
            errors++;
            $display("FAIL busy_release got front=%0b pos=%0d st=%0d exp 1/2/1",
                     front, front_pos, sched_state);
        end
    endtask

    task automatic test_reissue();
        prep();
        rob_head  = 4'd0;
        tag[7]    = 4'd2;
        tag[4]    = 4'd5;
        ent_valid = 16'h0080;
        ent_rdy   = 16'h0080;
        tick();
        checks++;
        if (front !== 1'b1 || front_pos !== 4'd7) begin
            errors++;
            $display("FAIL reissue_first got front=%0b pos=%0d exp 1/7", front, front_pos);
        end
        tick();
        checks++;
        if (front !== 1'b0 || sched_state !== 2'd0) begin
            errors++;
            $display("FAIL reissue_mask got front=%0b st=%0d exp 0/0", front, sched_state);
        end
        tick();
        tick();
        ent_valid = 16'h0090;
        ent_rdy   = 16'h0090;
        tick();
        checks++;
        if (front !== 1'b1 || front_pos !== 4'd7) begin
            errors++;
            $display("FAIL reissue_old got front=%0b pos=%0d exp 1/7", front, front_pos);
        end
        tick();
        checks++;
        if (front !== 1'b1 || front_pos !== 4'd4) begin
            errors++;
            $display("FAIL reissue_young got front=%0b pos=%0d exp 1/4", front, front_pos);
        end
    endtask

    task automatic test_clear();
        prep();
        rob_head = 4'($urandom);
        for (int i = 0; i < 16; i++) tag[i] = 4'($urandom);
        ent_valid = '1;
        ent_rdy   = '1;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (issue_cnt !== 32'd3 || front !== 1'b1) begin
            errors++;
            $display("FAIL clear_run got cnt=%0d front=%0b exp 3/1", issue_cnt, front);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (front !== 1'b0 || issue_cnt !== 32'd0 || sched_state !== 2'd0) begin
            errors++;
            $display("FAIL clear got front=%0b cnt=%0d st=%0d exp 0/0/0",
                     front, issue_cnt, sched_state);
        end
        clear = 1'b0;
        tick();
        checks++;
        if (front !== 1'b1 || issue_cnt !== 32'd1 || front_pos !== m_pos) begin
            errors++;
            $display("FAIL clear_resume got front=%0b cnt=%0d pos=%0d exp 1/1/%0d",
                     front, issue_cnt, front_pos, m_pos);
        end
    endtask

    task automatic test_stall();
        logic [3:0] held;
        prep();
        rob_head = 4'($urandom);
        for (int i = 0; i < 16; i++) tag[i] = 4'($urandom);
        ent_valid = '1;
        ent_rdy   = '1;
        tick();
        held = m_pos;
        ready     = 1'b0;
        ent_valid = '0;
        alu_busy  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clear = (c == 1);
            tick();
            checks++;
            if (front !== 1'b1 || front_pos !== held || issue_cnt !== 32'd1) begin
                errors++;
                $display("FAIL stall c=%0d got front=%0b pos=%0d cnt=%0d exp 1/%0d/1",
                         c, front, front_pos, issue_cnt, held);
            end
        end
        clear    = 1'b0;
        ready    = 1'b1;
        alu_busy = 1'b0;
        tick();
        checks++;
        if (front !== 1'b0 || sched_state !== 2'd0 || front_pos !== held) begin
            errors++;
            $display("FAIL stall_resume got front=%0b st=%0d pos=%0d exp 0/0/%0d",
                     front, sched_state, front_pos, held);
        end
        ent_valid = '1;
        tick();
        checks++;
        if (front !== 1'b1 || issue_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stall_reissue got front=%0b cnt=%0d exp 1/2", front, issue_cnt);
        end
    endtask

    task automatic test_random();
        prep();
        for (int c = 0; c < 600; c++) begin
            ent_valid = 16'($urandom);
            ent_rdy   = 16'($urandom) | 16'($urandom);
            if ($urandom_range(3) == 0) ent_valid = 16'(1 << $urandom_range(15));
            if ($urandom_range(7) == 0) rob_head = 4'($urandom);
            tag[$urandom_range(15)] = 4'($urandom);
            alu_busy = ($urandom_range(3) == 0);
            clear    = ($urandom_range(31) == 0);
            ready    = ($urandom_range(7) != 0);
            reset    = ($urandom_range(99) == 0);
            tick();
            checks++;
            if (front !== m_front || front_pos !== m_pos ||
                sched_state !== m_state || issue_cnt !== m_cnt) begin
                errors++;
                $display("FAIL random c=%0d got %0b/%0d/%0d/%0d exp %0b/%0d/%0d/%0d",
                         c, front, front_pos, sched_state, issue_cnt,
                         m_front, m_pos, m_state, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_age_wrap();
        test_busy_hold();
        test_reissue();
        test_clear();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
